// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic cells (adder now, subtractor planned).
// Holds the common FSM state encoding, the width ceiling and the one-bit helper functions.
package serial_arith_pkg;

    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic xor3(input logic x, input logic y, input logic z);
        return x ^ y ^ z;
    endfunction

    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Request/result bundle of the serial adder: operands and start in, status and result out.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin,
        input  busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin,
        output busy, done, sum, cout
    );
endinterface

// File: rtl/serial_adder_full_adder.sv
// One-bit combinational full-adder cell; the serial adder instantiates exactly one.
module full_adder
    import serial_arith_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = xor3(a, b, cin);
    assign cout = maj3(a, b, cin);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell plus a carry flop, one sum bit per clock.
// Result and carry-out are presented with a one-cycle done pulse WIDTH cycles after start.
module serial_adder
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1'b1);
    localparam logic [1:0]     ST_IDLE  = IDLE;
    localparam logic [1:0]     ST_SHIFT = SHIFT;
    localparam logic [1:0]     ST_DONE  = DONE;

    logic [1:0]       state_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic             carry_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             busy_r;
    logic             done_r;

    logic             fa_sum_s;
    logic             fa_cout_s;
    logic [WIDTH-1:0] sum_shift_s;
    logic [WIDTH-1:0] a_shift_s;
    logic [WIDTH-1:0] b_shift_s;

    full_adder u_fa (
        .a    (a_sh_r[0]),
        .b    (b_sh_r[0]),
        .cin  (carry_r),
        .sum  (fa_sum_s),
        .cout (fa_cout_s)
    );

    // Next shifted values; written with shifts so WIDTH=1 needs no empty slice.
    always_comb begin
        sum_shift_s              = sum_r >> 1;
        sum_shift_s[WIDTH-1]     = fa_sum_s;
        a_shift_s                = a_sh_r >> 1;
        b_shift_s                = b_sh_r >> 1;
    end

    // Control FSM, datapath registers and the registered status/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            count_r <= {CW{1'b0}};
            a_sh_r  <= {WIDTH{1'b0}};
            b_sh_r  <= {WIDTH{1'b0}};
            carry_r <= 1'b0;
            sum_r   <= {WIDTH{1'b0}};
            cout_r  <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_sh_r  <= bus.a;
                        b_sh_r  <= bus.b;
                        carry_r <= bus.cin;
                        count_r <= {CW{1'b0}};
                        sum_r   <= {WIDTH{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= ST_SHIFT;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    carry_r <= fa_cout_s;
                    sum_r   <= sum_shift_s;
                    a_sh_r  <= a_shift_s;
                    b_sh_r  <= b_shift_s;
                    count_r <= count_r + CNT_ONE;
                    // count still holds the pre-increment value, so this is the WIDTH-th edge
                    if (count_r == CNT_LAST) begin
                        cout_r  <= fa_cout_s;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= ST_SHIFT;
                    end
                end
                ST_DONE: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 directed + random operations, WIDTH=1 exhaustive.
module tb_serial_adder;

    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    always #5 clk = ~clk;

    serial_adder_if #(.WIDTH(W)) bus8 ();
    serial_adder_if #(.WIDTH(1)) bus1 ();

    serial_adder #(.WIDTH(W)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    serial_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // One WIDTH=8 addition; glitch>0 pulses a competing start on that SHIFT edge.
    task automatic do_add(input logic [7:0] av, input logic [7:0] bv, input logic ci, input int glitch);
        logic [8:0] exp;
        exp = 9'(av) + 9'(bv) + 9'(ci);
        bus8.start = 1'b1;
        bus8.a     = av;
        bus8.b     = bv;
        bus8.cin   = ci;
        step();
        bus8.start = 1'b0;
        bus8.a     = 8'($urandom);
        bus8.b     = 8'($urandom);
        bus8.cin   = 1'($urandom);
        check_value("busy_after_start", bus8.busy, 1);
        check_value("done_after_start", bus8.done, 0);
        for (int k = 1; k < W; k++) begin
            if (k == glitch) begin
                bus8.start = 1'b1;
                bus8.a     = 8'h77;
                bus8.b     = 8'h77;
            end
            step();
            bus8.start = 1'b0;
            check_value("busy_shift", bus8.busy, 1);
            check_value("done_shift", bus8.done, 0);
        end
        step();
        check_value("done_pulse", bus8.done, 1);
        check_value("busy_in_done", bus8.busy, 0);
        check_value("sum", bus8.sum, exp[7:0]);
        check_value("cout", bus8.cout, exp[8]);
        step();
        check_value("done_cleared", bus8.done, 0);
        step();
        check_value("no_second_done", bus8.done, 0);
        check_value("idle_busy", bus8.busy, 0);
        check_value("sum_held", bus8.sum, exp[7:0]);
    endtask

    initial begin
        logic [8:0] expq[$];
        int         dtimes[$];
        int         seen;
        logic [8:0] e9;
        logic [1:0] e2;
        logic       ai, bi, ci;

        bus8.start = 1'b0; bus8.a = 8'h00; bus8.b = 8'h00; bus8.cin = 1'b0;
        bus1.start = 1'b0; bus1.a = 1'b0;  bus1.b = 1'b0;  bus1.cin = 1'b0;
        rst = 1'b1;
        step();
        step();
        check_value("rst_busy", bus8.busy, 0);
        check_value("rst_done", bus8.done, 0);
        check_value("rst_sum", bus8.sum, 0);
        check_value("rst_cout", bus8.cout, 0);
        check_value("rst1_out", {bus1.busy, bus1.done, bus1.cout, bus1.sum}, 0);
        rst = 1'b0;
        step();

        do_add(8'h3C, 8'h5A, 1'b0, 0);
        do_add(8'hFF, 8'h01, 1'b0, 0);
        do_add(8'hFF, 8'hFF, 1'b1, 0);
        do_add(8'h10, 8'h20, 1'b0, 3);

        // Abort mid-operation with reset
        bus8.start = 1'b1; bus8.a = 8'h55; bus8.b = 8'hAA; bus8.cin = 1'b0;
        step();
        bus8.start = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        check_value("abort_busy", bus8.busy, 0);
        check_value("abort_done", bus8.done, 0);
        check_value("abort_sum", bus8.sum, 0);
        check_value("abort_cout", bus8.cout, 0);
        rst  = 1'b0;
        seen = 0;
        repeat (W + 4) begin
            step();
            if (bus8.done) seen++;
        end
        check_value("abort_no_done", seen, 0);
        do_add(8'($urandom), 8'($urandom), 1'($urandom), 0);

        for (int n = 0; n < 20; n++) begin
            do_add(8'($urandom), 8'($urandom), 1'($urandom), 0);
        end

        // Start held high: back-to-back operations with fresh operands after each done
        bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
        expq.push_back(9'(bus8.a) + 9'(bus8.b) + 9'(bus8.cin));
        bus8.start = 1'b1;
        for (int k = 0; k < 40 && dtimes.size() < 2; k++) begin
            step();
            if (bus8.done) begin
                dtimes.push_back(cyc);
                e9 = expq.pop_front();
                check_value("hold_sum", {bus8.cout, bus8.sum}, e9);
                if (dtimes.size() < 2) begin
                    bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
                    expq.push_back(9'(bus8.a) + 9'(bus8.b) + 9'(bus8.cin));
                end
            end
        end
        bus8.start = 1'b0;
        check_value("hold_pulses", dtimes.size(), 2);
        if (dtimes.size() == 2) check_value("hold_spacing", dtimes[1] - dtimes[0], W + 2);
        repeat (W + 4) step();

        // WIDTH=1 exhaustive
        for (int i = 0; i < 8; i++) begin
            ai = i[0]; bi = i[1]; ci = i[2];
            e2 = 2'(ai) + 2'(bi) + 2'(ci);
            bus1.a = ai; bus1.b = bi; bus1.cin = ci; bus1.start = 1'b1;
            step();
            bus1.start = 1'b0;
            check_value("w1_busy", bus1.busy, 1);
            check_value("w1_done_early", bus1.done, 0);
            step();
            check_value("w1_done", bus1.done, 1);
            check_value("w1_result", {bus1.cout, bus1.sum}, e2);
            step();
            check_value("w1_done_cleared", bus1.done, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
